// File: rtl/opsum_drain_pkg.sv
// opsum_drain shared types and constants.
// Build option: OPSUM_RELU_EN clamps negative opsums to zero on capture.
package opsum_drain_pkg;

  localparam int DEF_NUM_COL = 32;
  localparam int WORD_BYTES  = 4;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    POP,
    CAPT,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/opsum_rr_pick.sv
// Round-robin first-one finder: lowest set bit at or above ptr_i, with wrap.
// Pure combinational; shared by the opsum drain and the feeder units.
module opsum_rr_pick
  import opsum_drain_pkg::*;
#(
  parameter  int N  = DEF_NUM_COL,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  // Walk downward so the nearest candidate to ptr_i wins last.
  always_comb begin
    idx_o   = '0;
    found_o = |elig_i;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig_i[(int'(ptr_i) + i) % N]) begin
        idx_o = IW'((int'(ptr_i) + i) % N);
      end
    end
  end

endmodule

// File: rtl/opsum_drain.sv
// Drains finished opsums from the column FIFOs into the GLB, round-robin.
// Build option: OPSUM_RELU_EN zeroes negative words at capture.
module opsum_drain
  import opsum_drain_pkg::*;
#(
  parameter int NUM_COL = DEF_NUM_COL,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [NUM_COL-1:0] cfg_col_mask,
  input  logic [CNT_W-1:0]   cfg_words_per_col,
  input  logic [ADDR_W-1:0]  cfg_base_addr,
  input  logic [ADDR_W-1:0]  cfg_col_stride,
  input  logic [NUM_COL-1:0] opsum_fifo_empty,
  input  logic [DATA_W-1:0]  opsum_pop_data [NUM_COL],
  output logic [NUM_COL-1:0] opsum_pop_en,
  output logic [NUM_COL-1:0] opsum_pop_mod,
  output logic               glb_w_req,
  output logic [ADDR_W-1:0]  glb_w_addr,
  output logic [DATA_W-1:0]  glb_w_data,
  input  logic               glb_w_ack,
  output logic               busy_o,
  output logic               done_o
);

  localparam int IW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;

  state_e             state_q;
  logic [NUM_COL-1:0] mask_q;
  logic [CNT_W-1:0]   words_q;
  logic [ADDR_W-1:0]  base_q;
  logic [ADDR_W-1:0]  stride_q;
  logic [CNT_W-1:0]   cnt_q [NUM_COL];
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      sel_q;
  logic [NUM_COL-1:0] pop_en_q;
  logic               req_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic               busy_q;
  logic               done_q;

  logic [NUM_COL-1:0] elig;
  logic [NUM_COL-1:0] unfin;
  logic [IW-1:0]      pick_idx;
  logic               pick_found;
  logic [IW-1:0]      ptr_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  raw_d;
  logic [DATA_W-1:0]  data_d;

  always_comb begin
    elig  = '0;
    unfin = '0;
    for (int c = 0; c < NUM_COL; c++) begin
      unfin[c] = mask_q[c] && (cnt_q[c] < words_q);
      elig[c]  = unfin[c] && !opsum_fifo_empty[c];
    end
  end

  opsum_rr_pick #(
    .N(NUM_COL)
  ) u_pick (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .idx_o  (pick_idx),
    .found_o(pick_found)
  );

  assign ptr_d  = (sel_q == IW'(NUM_COL - 1)) ? '0 : sel_q + 1'b1;
  assign addr_d = base_q
                + ADDR_W'(sel_q) * stride_q
                + ADDR_W'(cnt_q[sel_q]) * ADDR_W'(WORD_BYTES);
  assign raw_d  = opsum_pop_data[sel_q];

`ifdef OPSUM_RELU_EN
  assign data_d = raw_d[DATA_W-1] ? '0 : raw_d;
`else
  assign data_d = raw_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      words_q  <= '0;
      base_q   <= '0;
      stride_q <= '0;
      for (int c = 0; c < NUM_COL; c++) cnt_q[c] <= '0;
      ptr_q    <= '0;
      sel_q    <= '0;
      pop_en_q <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      pop_en_q <= '0;
      done_q   <= 1'b0;
      unique case (state_q)
        IDLE: if (start_i) begin
          mask_q   <= cfg_col_mask;
          words_q  <= cfg_words_per_col;
          base_q   <= cfg_base_addr;
          stride_q <= cfg_col_stride;
          for (int c = 0; c < NUM_COL; c++) cnt_q[c] <= '0;
          ptr_q    <= '0;
          busy_q   <= 1'b1;
          state_q  <= SCAN;
        end
        SCAN: if (pick_found) begin
          sel_q    <= pick_idx;
          pop_en_q <= NUM_COL'(1) << pick_idx;
          state_q  <= POP;
        end else if (unfin == '0) begin
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        POP: state_q <= CAPT;
        CAPT: begin
          data_q  <= data_d;
          addr_q  <= addr_d;
          req_q   <= 1'b1;
          state_q <= WRITE;
        end
        WRITE: if (glb_w_ack) begin
          req_q        <= 1'b0;
          cnt_q[sel_q] <= cnt_q[sel_q] + 1'b1;
          ptr_q        <= ptr_d;
          state_q      <= SCAN;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign opsum_pop_en  = pop_en_q;
  assign opsum_pop_mod = '1;
  assign glb_w_req     = req_q;
  assign glb_w_addr    = addr_q;
  assign glb_w_data    = data_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_opsum_drain.sv
// Self-checking bench for opsum_drain with FIFO and GLB models.
// Build with +define+OPSUM_RELU_EN to check the clamping variant.
module tb_opsum_drain;

  localparam int NC  = 32;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int CW  = 16;
  localparam int DEP = 64;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          start_i = 0;
  logic [NC-1:0] cfg_col_mask = '0;
  logic [CW-1:0] cfg_words_per_col = '0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [AW-1:0] cfg_col_stride = '0;
  logic [NC-1:0] opsum_fifo_empty = '1;
  logic [DW-1:0] opsum_pop_data [NC];
  logic [NC-1:0] opsum_pop_en;
  logic [NC-1:0] opsum_pop_mod;
  logic          glb_w_req;
  logic [AW-1:0] glb_w_addr;
  logic [DW-1:0] glb_w_data;
  logic          glb_w_ack = 0;
  logic          busy_o;
  logic          done_o;

  opsum_drain #(
    .NUM_COL(NC), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .cfg_col_mask(cfg_col_mask),
    .cfg_words_per_col(cfg_words_per_col),
    .cfg_base_addr(cfg_base_addr),
    .cfg_col_stride(cfg_col_stride),
    .opsum_fifo_empty(opsum_fifo_empty),
    .opsum_pop_data(opsum_pop_data),
    .opsum_pop_en(opsum_pop_en),
    .opsum_pop_mod(opsum_pop_mod),
    .glb_w_req(glb_w_req), .glb_w_addr(glb_w_addr),
    .glb_w_data(glb_w_data), .glb_w_ack(glb_w_ack),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_pops = 0;

  logic [DW-1:0] mem [NC][DEP];
  int            head [NC];
  int            tail [NC];
  logic [NC-1:0] force_e = '0;

  wr_t act_q[$];
  wr_t exp_q[$];
  int  ack_delay = 0;
  int  wcnt = 0;
  logic [AW-1:0] h_a;
  logic [DW-1:0] h_d;

  // FIFO model: read data appears the cycle after a pop.
  always @(posedge clk) begin
    if (opsum_pop_en != '0) begin
      n_chk++;
      if ($countones(opsum_pop_en) != 1) begin
        n_fail++;
        $display("FAIL pop_onehot: pop_en=%h required one-hot", opsum_pop_en);
      end
    end
    for (int c = 0; c < NC; c++) begin
      if (opsum_pop_en[c]) begin
        n_chk++;
        if (head[c] == tail[c]) begin
          n_fail++;
          $display("FAIL pop_empty: col %0d popped while empty, required no pop", c);
        end else begin
          opsum_pop_data[c] <= mem[c][head[c] % DEP];
          head[c] = head[c] + 1;
          n_pops++;
        end
      end
      opsum_fifo_empty[c] <= (head[c] == tail[c]) || force_e[c];
    end
  end

  // GLB model: acks after ack_delay cycles of req, checks request stability.
  always @(negedge clk) begin
    if (!rst_n || !glb_w_req) begin
      glb_w_ack = 0;
      wcnt = 0;
    end else begin
      if (wcnt == 0) begin
        h_a = glb_w_addr;
        h_d = glb_w_data;
      end else begin
        n_chk++;
        if (glb_w_addr !== h_a || glb_w_data !== h_d) begin
          n_fail++;
          $display("FAIL w_stable: addr/data %h/%h changed, required %h/%h",
                   glb_w_addr, glb_w_data, h_a, h_d);
        end
      end
      if (wcnt >= ack_delay) begin
        glb_w_ack = 1;
        act_q.push_back('{a: glb_w_addr, d: glb_w_data});
      end
      wcnt++;
    end
  end

  function automatic logic [DW-1:0] xf(logic [DW-1:0] d);
`ifdef OPSUM_RELU_EN
    return d[DW-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  function automatic logic [DW-1:0] peek(int c, int k);
    return mem[c][(head[c] + k) % DEP];
  endfunction

  task automatic load(int c, logic [DW-1:0] d);
    mem[c][tail[c] % DEP] = d;
    tail[c] = tail[c] + 1;
  endtask

  task automatic pulse_start(logic [NC-1:0] m, logic [CW-1:0] w,
                             logic [AW-1:0] b, logic [AW-1:0] s);
    cfg_col_mask = m;
    cfg_words_per_col = w;
    cfg_base_addr = b;
    cfg_col_stride = s;
    start_i = 1;
    @(negedge clk);
    start_i = 0;
  endtask

  task automatic wait_done(int maxc, output bit ok);
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      if (done_o) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Reference drain order: each write goes to the first unfinished
  // masked column at or after the one following the previous write.
  task automatic model(logic [NC-1:0] m, int w, logic [AW-1:0] b,
                       logic [AW-1:0] s);
    int taken [NC];
    int ptr = 0;
    int total = 0;
    exp_q.delete();
    for (int c = 0; c < NC; c++) begin
      taken[c] = 0;
      if (m[c]) total += w;
    end
    for (int n = 0; n < total; n++) begin
      for (int i = 0; i < NC; i++) begin
        int c;
        c = (ptr + i) % NC;
        if (m[c] && taken[c] < w) begin
          exp_q.push_back('{a: b + AW'(c) * s + AW'(taken[c] * 4),
                            d: xf(peek(c, taken[c]))});
          taken[c]++;
          ptr = (c + 1) % NC;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (opsum_pop_mod !== '1) begin
      n_fail++;
      $display("FAIL rst_pop_mod: %h required all ones", opsum_pop_mod);
    end
    n_chk++;
    if ({opsum_pop_en, glb_w_req, glb_w_addr, glb_w_data, busy_o, done_o} !== '0) begin
      n_fail++;
      $display("FAIL rst_outputs: en=%h req=%b addr=%h data=%h busy=%b done=%b required all 0",
               opsum_pop_en, glb_w_req, glb_w_addr, glb_w_data, busy_o, done_o);
    end
    rst_n = 1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (busy_o !== 0 || glb_w_req !== 0) begin
      n_fail++;
      $display("FAIL idle_quiet: busy=%b req=%b required 0/0", busy_o, glb_w_req);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int p0;
    logic [AW-1:0] ea [3];
    logic [DW-1:0] ed [3];
    ea[0] = 32'h1000; ea[1] = 32'h1004; ea[2] = 32'h1008;
    ed[0] = 32'd11;   ed[1] = 32'd22;   ed[2] = 32'd33;
    load(0, 32'd11); load(0, 32'd22); load(0, 32'd33);
    repeat (2) @(negedge clk);
    act_q.delete();
    ack_delay = 0;
    p0 = n_pops;
    pulse_start(32'h1, 16'd3, 32'h1000, 32'h0);
    n_chk++;
    if (busy_o !== 1 || opsum_pop_en !== '0) begin
      n_fail++;
      $display("FAIL basic_t1: busy=%b en=%h required 1/0", busy_o, opsum_pop_en);
    end
    @(negedge clk);
    n_chk++;
    if (opsum_pop_en !== 32'h1) begin
      n_fail++;
      $display("FAIL basic_t2_pop: en=%h required 00000001", opsum_pop_en);
    end
    wait_done(200, ok);
    n_chk++;
    if (!ok || busy_o !== 0) begin
      n_fail++;
      $display("FAIL basic_done: seen=%0d busy=%b required 1/0", ok, busy_o);
    end
    @(negedge clk);
    n_chk++;
    if (done_o !== 0) begin
      n_fail++;
      $display("FAIL basic_done_width: done=%b required 0", done_o);
    end
    n_chk++;
    if (act_q.size() != 3 || n_pops - p0 != 3) begin
      n_fail++;
      $display("FAIL basic_count: writes=%0d pops=%0d required 3/3",
               act_q.size(), n_pops - p0);
    end
    for (int i = 0; i < 3 && i < act_q.size(); i++) begin
      n_chk++;
      if (act_q[i].a !== ea[i] || act_q[i].d !== xf(ed[i])) begin
        n_fail++;
        $display("FAIL basic_wr%0d: %h/%h required %h/%h",
                 i, act_q[i].a, act_q[i].d, ea[i], xf(ed[i]));
      end
    end
  endtask

  task automatic test_relu();
    bit ok;
    logic [DW-1:0] neg;
    neg = 32'hFFFF_FFF6;
    load(4, neg);
    load(4, 32'd7);
    repeat (2) @(negedge clk);
    act_q.delete();
    pulse_start(32'h10, 16'd1, 32'h0, 32'h10);
    wait_done(100, ok);
    @(negedge clk);
    n_chk++;
`ifdef OPSUM_RELU_EN
    if (!ok || act_q.size() != 1 || act_q[0] !== {32'h40, 32'h0}) begin
`else
    if (!ok || act_q.size() != 1 || act_q[0] !== {32'h40, 32'hFFFF_FFF6}) begin
`endif
      n_fail++;
      $display("FAIL relu_word: done=%0d n=%0d wr=%h required 1 write of %h",
               ok, act_q.size(), act_q.size() > 0 ? act_q[0] : '0, {32'h40, xf(neg)});
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int p0;
    logic [AW-1:0] ea [4];
    logic [DW-1:0] ed [4];
    for (int k = 0; k < 2; k++) begin
      load(0, $urandom);
      load(2, $urandom);
    end
    repeat (2) @(negedge clk);
    ea[0] = 32'h1000; ea[1] = 32'h1200; ea[2] = 32'h1004; ea[3] = 32'h1204;
    ed[0] = peek(0, 0); ed[1] = peek(2, 0); ed[2] = peek(0, 1); ed[3] = peek(2, 1);
    act_q.delete();
    p0 = n_pops;
    pulse_start(32'h5, 16'd2, 32'h1000, 32'h100);
    repeat (4) @(negedge clk);
    pulse_start('1, 16'd9, 32'h8000, 32'h4);
    n_chk++;
    if (busy_o !== 1) begin
      n_fail++;
      $display("FAIL rr_busy_mid: busy=%b required 1", busy_o);
    end
    wait_done(200, ok);
    @(negedge clk);
    n_chk++;
    if (!ok || act_q.size() != 4 || n_pops - p0 != 4) begin
      n_fail++;
      $display("FAIL rr_count: done=%0d writes=%0d pops=%0d required 1/4/4",
               ok, act_q.size(), n_pops - p0);
    end
    for (int i = 0; i < 4 && i < act_q.size(); i++) begin
      n_chk++;
      if (act_q[i].a !== ea[i] || act_q[i].d !== xf(ed[i])) begin
        n_fail++;
        $display("FAIL rr_wr%0d: %h/%h required %h/%h",
                 i, act_q[i].a, act_q[i].d, ea[i], xf(ed[i]));
      end
    end
  endtask

  task automatic test_stall_backpressure();
    bit ok;
    int p0;
    int bad;
    logic [AW-1:0] ea [4];
    logic [DW-1:0] ed [4];
    force_e[1] = 1;
    for (int k = 0; k < 2; k++) begin
      load(0, $urandom);
      load(1, $urandom);
    end
    repeat (2) @(negedge clk);
    ea[0] = 32'h2000; ea[1] = 32'h2004; ea[2] = 32'h2040; ea[3] = 32'h2044;
    ed[0] = peek(0, 0); ed[1] = peek(0, 1); ed[2] = peek(1, 0); ed[3] = peek(1, 1);
    act_q.delete();
    ack_delay = 0;
    p0 = n_pops;
    pulse_start(32'h3, 16'd2, 32'h2000, 32'h40);
    for (int i = 0; i < 100 && act_q.size() < 2; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (opsum_pop_en !== '0 || glb_w_req !== 0 || busy_o !== 1) bad++;
      @(negedge clk);
    end
    n_chk++;
    if (bad != 0 || act_q.size() != 2) begin
      n_fail++;
      $display("FAIL stall_scan: bad_cycles=%0d writes=%0d required 0/2",
               bad, act_q.size());
    end
    ack_delay = 5;
    force_e[1] = 0;
    wait_done(300, ok);
    @(negedge clk);
    ack_delay = 0;
    n_chk++;
    if (!ok || act_q.size() != 4 || n_pops - p0 != 4) begin
      n_fail++;
      $display("FAIL stall_count: done=%0d writes=%0d pops=%0d required 1/4/4",
               ok, act_q.size(), n_pops - p0);
    end
    for (int i = 0; i < 4 && i < act_q.size(); i++) begin
      n_chk++;
      if (act_q[i].a !== ea[i] || act_q[i].d !== xf(ed[i])) begin
        n_fail++;
        $display("FAIL stall_wr%0d: %h/%h required %h/%h",
                 i, act_q[i].a, act_q[i].d, ea[i], xf(ed[i]));
      end
    end
  endtask

  task automatic test_zero_config();
    int p0;
    for (int t = 0; t < 2; t++) begin
      act_q.delete();
      p0 = n_pops;
      if (t == 0) pulse_start(32'h0, 16'd4, 32'h0, 32'h0);
      else        pulse_start(32'hF, 16'd0, 32'h0, 32'h0);
      n_chk++;
      if (busy_o !== 1 || done_o !== 0) begin
        n_fail++;
        $display("FAIL zero%0d_t1: busy=%b done=%b required 1/0", t, busy_o, done_o);
      end
      @(negedge clk);
      n_chk++;
      if (done_o !== 1 || busy_o !== 0) begin
        n_fail++;
        $display("FAIL zero%0d_t2: done=%b busy=%b required 1/0", t, done_o, busy_o);
      end
      repeat (2) @(negedge clk);
      n_chk++;
      if (act_q.size() != 0 || n_pops != p0 || done_o !== 0) begin
        n_fail++;
        $display("FAIL zero%0d_quiet: writes=%0d pops=%0d done=%b required 0/0/0",
                 t, act_q.size(), n_pops - p0, done_o);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    load(3, $urandom);
    load(3, $urandom);
    repeat (2) @(negedge clk);
    act_q.delete();
    ack_delay = 100;
    pulse_start(32'h8, 16'd2, 32'h3000, 32'h20);
    for (int i = 0; i < 50 && !glb_w_req; i++) @(negedge clk);
    rst_n = 0;
    #1;
    n_chk++;
    if (glb_w_req !== 0 || opsum_pop_en !== '0 || busy_o !== 0) begin
      n_fail++;
      $display("FAIL rst_mid: req=%b en=%h busy=%b required 0/0/0",
               glb_w_req, opsum_pop_en, busy_o);
    end
    @(negedge clk);
    rst_n = 1;
    ack_delay = 0;
    load(3, $urandom);
    repeat (2) @(negedge clk);
    model(32'h8, 2, 32'h3000, 32'h20);
    act_q.delete();
    pulse_start(32'h8, 16'd2, 32'h3000, 32'h20);
    wait_done(200, ok);
    @(negedge clk);
    n_chk++;
    if (!ok || act_q.size() != 2) begin
      n_fail++;
      $display("FAIL rst_restart_count: done=%0d writes=%0d required 1/2", ok, act_q.size());
    end
    for (int i = 0; i < 2 && i < act_q.size(); i++) begin
      n_chk++;
      if (act_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rst_restart_wr%0d: %h required %h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int p0;
    logic [NC-1:0] m;
    int w;
    logic [AW-1:0] b;
    logic [AW-1:0] s;
    for (int it = 0; it < 5; it++) begin
      m = (it % 2 == 0) ? ($urandom & $urandom) : NC'($urandom);
      w = $urandom_range(1, 3);
      b = $urandom & 32'hFFFF_FFFC;
      s = $urandom & 32'h0000_FFF0;
      for (int c = 0; c < NC; c++)
        if (m[c])
          for (int k = 0; k < w; k++) load(c, $urandom);
      repeat (2) @(negedge clk);
      model(m, w, b, s);
      act_q.delete();
      ack_delay = $urandom_range(0, 2);
      p0 = n_pops;
      pulse_start(m, CW'(w), b, s);
      wait_done(4000, ok);
      @(negedge clk);
      n_chk++;
      if (!ok || act_q.size() != exp_q.size() || n_pops - p0 != exp_q.size()) begin
        n_fail++;
        $display("FAIL rand%0d_count: done=%0d writes=%0d pops=%0d required 1/%0d/%0d",
                 it, ok, act_q.size(), n_pops - p0, exp_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
        n_chk++;
        if (act_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rand%0d_wr%0d: %h required %h", it, i, act_q[i], exp_q[i]);
        end
      end
    end
    ack_delay = 0;
  endtask

  initial begin
    for (int c = 0; c < NC; c++) opsum_pop_data[c] = '0;
    test_reset();
    test_basic();
    test_relu();
    test_round_robin();
    test_stall_backpressure();
    test_zero_config();
    test_reset_mid_write();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
